// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an extra pointer MSB
// to tell full from empty and a registered occupancy count.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  push, pop;

    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign dout  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign count = count_q;

    // Next pointers and occupancy from the accepted push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: host bytes go through a FIFO into a framer
// that emits 8N1/8N2 frames with an internal per-bit cycle counter.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 4,
    parameter int unsigned CLKS_PER_BIT    = 16,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     uart_tx,
    output logic                     tx_busy,
    output logic [FIFO_ADDR_WIDTH:0] fifo_count
);

    localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = cnt_width(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  baud_end;

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_valid),
        .din   (wr_data),
        .full  (fifo_full),
        .rd_en (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_ready = !fifo_full;
    assign tx_busy  = (state_q != IDLE);
    assign uart_tx  = tx_q;
    assign baud_end = (baud_q == BAUD_LAST);

    // Framer: sequence start/data/stop bits and pull the next byte when free.
    // The line level is derived from the next state so the output register
    // changes on the same edge as the state it belongs to.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_dout;
                            state_d  = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   tx_d = UART_START_LEVEL;
            DATA:    tx_d = shift_d[0];
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // Framer state, counters, shifter and registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised bench for uart_tx_buffered against a frame-timing reference
// model, plus a directed 8N2 frame on a second instance.
module tb_uart_tx_buffered;

    localparam int CPB   = 16;
    localparam int STOPS = 1;
    localparam int FRAME = (1 + 8 + STOPS) * CPB;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data, wr_data2;
    logic       wr_valid, wr_valid2;
    logic       wr_ready, wr_ready2;
    logic       uart_tx, uart_tx2;
    logic       tx_busy, tx_busy2;
    logic [4:0] fifo_count, fifo_count2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    uart_tx_buffered dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    uart_tx_buffered #(
        .DATA_WIDTH      (8),
        .FIFO_ADDR_WIDTH (4),
        .CLKS_PER_BIT    (4),
        .STOP_BITS       (2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data2),
        .wr_valid   (wr_valid2),
        .wr_ready   (wr_ready2),
        .uart_tx    (uart_tx2),
        .tx_busy    (tx_busy2),
        .fifo_count (fifo_count2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level k cycles into a frame of byte b (k<0 or past the end: idle).
    function automatic logic frame_level(input int k, input logic [7:0] b,
                                         input int cpb, input int stops);
        int p;
        if (k < 0) return 1'b1;
        p = k / cpb;
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        if (p < 9 + stops) return 1'b1;
        return 1'b1;
    endfunction

    // Reference model: queue of stored bytes and the frame on the line.
    logic [7:0] mq[$];
    bit         act = 0;
    int         fs  = 0;
    int         cyc = 0;
    logic [7:0] fb  = '0;

    initial begin
        bit acc, last;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                act = 0;
            end else begin
                acc  = wr_valid && (mq.size() < DEPTH);
                last = act && (cyc == fs + FRAME - 1);
                if ((!act || last) && mq.size() != 0) begin
                    fb  = mq.pop_front();
                    fs  = cyc + 1;
                    act = 1;
                end else if (last) begin
                    act = 0;
                end
                if (acc) mq.push_back(wr_data);
            end
            cyc++;
        end
    end

    // Per-cycle comparison of the main instance against the model.
    initial begin
        logic el, eb, er;
        int   ec;
        forever begin
            @(negedge clk);
            if (rst) begin
                el = 1'b1; eb = 1'b0; ec = 0; er = 1'b1;
            end else begin
                el = act ? frame_level(cyc - fs, fb, CPB, STOPS) : 1'b1;
                eb = act;
                ec = mq.size();
                er = (mq.size() < DEPTH);
            end
            check_eq("uart_tx", uart_tx, el);
            check_eq("tx_busy", tx_busy, eb);
            check_eq("fifo_count", fifo_count, ec);
            check_eq("wr_ready", wr_ready, er);
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        wr_valid = v;
        wr_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!tx_busy && fifo_count == 0) done = 1;
        end
        check_eq(tag, done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_acc;
        int k;
        rst = 1'b1;
        wr_valid = 1'b0; wr_data = '0;
        wr_valid2 = 1'b0; wr_data2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 8N2 at 4 clocks per bit on the second instance: 44-cycle frame.
        wr_valid2 = 1'b1; wr_data2 = 8'h3C;
        @(posedge clk); #1;
        wr_valid2 = 1'b0;
        for (int i = 0; i < 52; i++) begin
            @(negedge clk);
            k = i - 1;
            check_eq("d2_tx", uart_tx2, frame_level(k, 8'h3C, 4, 2));
            check_eq("d2_busy", tx_busy2, (k >= 0 && k < 44));
            check_eq("d2_count", fifo_count2, (k == -1) ? 1 : 0);
            check_eq("d2_ready", wr_ready2, 1);
        end
        @(posedge clk); #1;

        // Single byte.
        drive(1'b1, 8'hA5);
        wr_valid = 1'b0;
        wait_idle("idle_single", 400);

        // Back-to-back frames.
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h55);
        wr_valid = 1'b0;
        wait_idle("idle_b2b", 700);

        // Overflow: valid held with incrementing data.
        n_acc = 0;
        for (int i = 0; i < 25; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            @(negedge clk);
            if (wr_ready) n_acc++;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        check_eq("ovf_accepted", n_acc, 17);
        @(negedge clk);
        check_eq("ovf_full_count", fifo_count, 16);
        check_eq("ovf_full_ready", wr_ready, 0);
        @(posedge clk); #1;
        wait_idle("idle_ovf", 17 * FRAME + 200);

        // Pointer wrap: 10 then 12 bytes.
        for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom));
        wr_valid = 1'b0;
        wait_idle("idle_wrap1", 11 * FRAME + 200);
        for (int i = 0; i < 12; i++) drive(1'b1, 8'($urandom));
        wr_valid = 1'b0;
        wait_idle("idle_wrap2", 13 * FRAME + 200);

        // Random traffic, frequently hitting full.
        for (int i = 0; i < 2000; i++)
            drive(($urandom_range(0, 99) < 12), 8'($urandom));
        wr_valid = 1'b0;
        wait_idle("idle_rand", 17 * FRAME + 200);

        // Reset during data bit 3 of a zero byte with four bytes queued.
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h33);
        drive(1'b1, 8'h44);
        wr_valid = 1'b0;
        repeat (65) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_async_tx", uart_tx, 1);
        check_eq("rst_async_busy", tx_busy, 0);
        check_eq("rst_async_count", fifo_count, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) drive(1'b0, 8'h00);
        drive(1'b1, 8'h5A);
        wr_valid = 1'b0;
        wait_idle("idle_post_rst", 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
